alu_wb_arbiter: RTL and testbench



---
 rtl/alu_wb_arbiter_pkg.sv | 19 +
 rtl/alu_wb_arbiter_rr_multi_picker.sv | 44 ++++
 rtl/alu_wb_arbiter.sv | 90 +++++++++
 tb/tb_alu_wb_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_arbiter_pkg.sv
// Shared types and instance constants for the ALU writeback arbiter.
// The writeback payload type is comwbInfo_t, and the package also provides a small index-wrap helper.
package alu_wb_arbiter_pkg;

    localparam int NUM_ALU        = 4;
    localparam int NUM_ALU_WBPORT = 2;

    typedef struct packed {
        logic        rd_wen;
        logic [4:0]  rd_idx;
        logic [5:0]  rob_idx;
        logic [31:0] rd_data;
    } comwbInfo_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu_wb_arbiter_rr_multi_picker.sv
// Combinational round-robin picker that grants up to P of N requests, starting the scan at start.
// The k-th grant in scan order drives port_sel[k]. last_idx is the index of the final grant.
module rr_multi_picker #(
    parameter int N = 4,
    parameter int P = 2
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  start,
    output logic [N-1:0]          grant,
    output logic [P-1:0][N-1:0]   port_sel,
    output logic [$clog2(N)-1:0]  last_idx,
    output logic                  any_grant
);

    localparam int PW = $clog2(N);

    always_comb begin
        int cnt;
        int idx_int;
        logic [PW-1:0] idx;
        grant     = '0;
        port_sel  = '0;
        last_idx  = '0;
        any_grant = 1'b0;
        cnt       = 0;
        idx_int   = 0;
        idx       = '0;
        for (int o = 0; o < N; o++) begin
            idx_int = int'(start) + o;
            if (idx_int >= N) idx_int = idx_int - N;
            idx = PW'(idx_int);
            if (req[idx] && cnt < P) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < P; k++) begin
                    if (k == cnt) port_sel[k][idx] = 1'b1;
                end
                last_idx  = idx;
                any_grant = 1'b1;
                cnt       = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Round-robin arbiter that shares NUM_WBPORT registered writeback ports among NUM_FU ALUs.
// Defining ALU_WB_ARB_PERF_CNT_EN adds saturating conflict and block counters.
module alu_wb_arbiter
    import alu_wb_arbiter_pkg::*;
#(
    parameter int NUM_FU     = NUM_ALU,
    parameter int NUM_WBPORT = NUM_ALU_WBPORT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FU-1:0]           i_fu_finished,
    input  comwbInfo_t                  i_fu_comwbInfo [NUM_FU],
    output logic [NUM_FU-1:0]           o_fu_wb_stall,
    input  logic                        i_wb_block,
    output logic [NUM_WBPORT-1:0]       o_wb_vld,
    output comwbInfo_t                  o_wb_comwbInfo [NUM_WBPORT],
`ifdef ALU_WB_ARB_PERF_CNT_EN
    output logic [31:0]                 o_perf_conflict_cnt,
    output logic [31:0]                 o_perf_block_cnt,
`endif
    output logic [$clog2(NUM_FU)-1:0]   o_rr_ptr
);

    localparam int PW = $clog2(NUM_FU);

    // Handshake: i_fu_finished is a valid. An ALU's result is consumed in the cycle
    // where finished=1 and stall=0. While it is stalled, the ALU holds finished and its payload.
    logic [NUM_FU-1:0]                req_eff;
    logic [NUM_FU-1:0]                grant;
    logic [NUM_WBPORT-1:0][NUM_FU-1:0] port_sel;
    logic [PW-1:0]                    last_idx;
    logic                             any_grant;
    logic [PW-1:0]                    rr_ptr;
    logic [NUM_WBPORT-1:0]            port_vld;
    comwbInfo_t                       port_info [NUM_WBPORT];

    assign req_eff = i_fu_finished & {NUM_FU{~i_wb_block}};

    rr_multi_picker #(
        .N (NUM_FU),
        .P (NUM_WBPORT)
    ) u_picker (
        .req       (req_eff),
        .start     (rr_ptr),
        .grant     (grant),
        .port_sel  (port_sel),
        .last_idx  (last_idx),
        .any_grant (any_grant)
    );

    assign o_fu_wb_stall = i_fu_finished & ~grant;
    assign o_rr_ptr      = rr_ptr;

    always_comb begin
        for (int k = 0; k < NUM_WBPORT; k++) begin
            port_vld[k]  = |port_sel[k];
            port_info[k] = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (port_sel[k][i]) port_info[k] = i_fu_comwbInfo[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            o_wb_vld <= '0;
            for (int k = 0; k < NUM_WBPORT; k++) o_wb_comwbInfo[k] <= '0;
        end else begin
            o_wb_vld <= port_vld;
            for (int k = 0; k < NUM_WBPORT; k++) o_wb_comwbInfo[k] <= port_info[k];
            if (any_grant) rr_ptr <= PW'(wrap_inc(int'(last_idx), NUM_FU));
        end
    end

`ifdef ALU_WB_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_conflict_cnt <= '0;
            o_perf_block_cnt    <= '0;
        end else begin
            if (!i_wb_block && (|o_fu_wb_stall) && (o_perf_conflict_cnt != '1))
                o_perf_conflict_cnt <= o_perf_conflict_cnt + 32'd1;
            if (i_wb_block && (|i_fu_finished) && (o_perf_block_cnt != '1))
                o_perf_block_cnt <= o_perf_block_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_wb_arbiter.sv
// Self-checking bench for alu_wb_arbiter. It combines directed scenarios with randomized traffic,
// and checks the results against a scan-order reference model.
module tb_alu_wb_arbiter;
    import alu_wb_arbiter_pkg::*;

    localparam int N  = NUM_ALU;
    localparam int P  = NUM_ALU_WBPORT;
    localparam int PW = $clog2(N);
    localparam int CW = $bits(comwbInfo_t);
    localparam int EW = P + P * CW;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]  fin;
    logic [N-1:0]  stall;
    logic          blk;
    comwbInfo_t    fu_info [N];
    logic [P-1:0]  wb_vld;
    comwbInfo_t    wb_info [P];
    logic [PW-1:0] rr;
`ifdef ALU_WB_ARB_PERF_CNT_EN
    logic [31:0]   conf_cnt;
    logic [31:0]   blk_cnt;
`endif

    alu_wb_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_fu_finished       (fin),
        .i_fu_comwbInfo      (fu_info),
        .o_fu_wb_stall       (stall),
        .i_wb_block          (blk),
        .o_wb_vld            (wb_vld),
        .o_wb_comwbInfo      (wb_info),
`ifdef ALU_WB_ARB_PERF_CNT_EN
        .o_perf_conflict_cnt (conf_cnt),
        .o_perf_block_cnt    (blk_cnt),
`endif
        .o_rr_ptr            (rr)
    );

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model state
    int          m_rr = 0;
    logic [N-1:0] m_stall_prev = '0;
    longint      m_conf = 0;
    longint      m_blk  = 0;
    int          win_q[$];

    function automatic comwbInfo_t new_payload();
        comwbInfo_t p;
        p.rd_wen  = ($urandom_range(0, 3) != 0);
        p.rd_idx  = 5'($urandom_range(0, 31));
        p.rob_idx = 6'($urandom_range(0, 63));
        p.rd_data = $urandom();
        return p;
    endfunction

    // driver: one clock cycle, called at a negedge
    task automatic step(input logic [N-1:0] f, input logic b, input logic r);
        logic [N-1:0]  exp_stall;
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        comwbInfo_t    ep;
        int            idx;
        rst = r;
        blk = b;
        fin = f;
        for (int i = 0; i < N; i++) if (!m_stall_prev[i]) fu_info[i] = new_payload();
        win_q.delete();
        exp_stall = f;
        if (!b) begin
            for (int o = 0; o < N; o++) begin
                idx = (m_rr + o) % N;
                if (f[idx] && win_q.size() < P) begin
                    win_q.push_back(idx);
                    exp_stall[idx] = 1'b0;
                end
            end
        end
        #1;
        if (!r || f == '0) check("stall", 64'(stall), 64'(exp_stall));
        e = '0;
        for (int k = 0; k < win_q.size(); k++) begin
            e[k] = 1'b1;
            e[P + k*CW +: CW] = fu_info[win_q[k]];
        end
        @(posedge clk);
        if (r) begin
            m_rr = 0;
            m_conf = 0;
            m_blk = 0;
            e = '0;
            m_stall_prev = '0;
        end else begin
            if (!b && exp_stall != '0 && m_conf < 64'hFFFF_FFFF) m_conf++;
            if (b && f != '0 && m_blk < 64'hFFFF_FFFF) m_blk++;
            if (win_q.size() > 0) m_rr = (win_q[win_q.size()-1] + 1) % N;
            m_stall_prev = exp_stall;
        end
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check("wb_vld", 64'(wb_vld), 64'(got[P-1:0]));
        for (int k = 0; k < P; k++) begin
            ep = comwbInfo_t'(got[P + k*CW +: CW]);
            if (got[k]) check($sformatf("port%0d_payload", k), 64'(wb_info[k]), 64'(ep));
            else        check($sformatf("port%0d_rd_wen", k), 64'(wb_info[k].rd_wen), 64'(0));
        end
        check("rr_ptr", 64'(rr), 64'(m_rr));
`ifdef ALU_WB_ARB_PERF_CNT_EN
        check("conflict_cnt", 64'(conf_cnt), 64'(m_conf));
        check("block_cnt", 64'(blk_cnt), 64'(m_blk));
`endif
    endtask

    initial begin
        logic [N-1:0] f;
        rst = 1'b1;
        blk = 1'b0;
        fin = '0;
        for (int i = 0; i < N; i++) fu_info[i] = '0;
        @(negedge clk);

        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);

        step(N'(4'b0101), 1'b0, 1'b0);
        check("dir_0101_vld", 64'(wb_vld), 64'(2'b11));
        check("dir_0101_p1_fu2", 64'(wb_info[1]), 64'(fu_info[2]));
        check("dir_0101_rr", 64'(rr), 64'(3));

        step(N'(4'b1001), 1'b0, 1'b0);
        check("dir_1001_p0_fu3", 64'(wb_info[0]), 64'(fu_info[3]));
        check("dir_1001_rr", 64'(rr), 64'(1));

        step(N'(4'b1111), 1'b0, 1'b0);
        step(N'(4'b1111), 1'b0, 1'b0);

        repeat (3) begin
            step(N'(4'b0011), 1'b1, 1'b0);
            check("dir_block_vld", 64'(wb_vld), 64'(0));
        end
        step(N'(4'b0011), 1'b0, 1'b0);
        check("dir_release_vld", 64'(wb_vld), 64'(2'b11));

        step(N'(4'b1111), 1'b0, 1'b0);
        step(N'(4'b1111), 1'b0, 1'b1);
        check("dir_midrst_vld", 64'(wb_vld), 64'(0));
        step(N'(4'b1111), 1'b0, 1'b0);
        check("dir_postrst_p0_fu0", 64'(wb_info[0]), 64'(fu_info[0]));
        check("dir_postrst_rr", 64'(rr), 64'(2));

`ifdef ALU_WB_ARB_PERF_CNT_EN
        step('0, 1'b0, 1'b1);
        repeat (5) step(N'(4'b0111), 1'b0, 1'b0);
        check("dir_conflict5", 64'(conf_cnt), 64'(5));
`endif

        for (int c = 0; c < 400; c++) begin
            f = m_stall_prev;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 9) < 6) f[i] = 1'b1;
            step(f, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
